// File: rtl/sr_drive_pkg.sv
// Shared definitions for sr_drive_ctrl: FSM state encodings, default
// parameter values and the minimum spacing between latch pulses.
package sr_drive_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SET_P = 2'd1;
   localparam logic [1:0] ST_RST_P = 2'd2;
   localparam logic [1:0] ST_GUARD = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SET_P = ST_SET_P,
      RST_P = ST_RST_P,
      GUARD = ST_GUARD
   } state_t;

   localparam int DEF_SYNC_STAGES  = 2;
   localparam int DEF_DB_CYCLES    = 4;
   localparam int DEF_PULSE_CYCLES = 2;
   localparam int DEF_CNT_W        = 8;

   // Cycles from the fall of one pulse to the rise of the next (GUARD + IDLE decision)
   localparam int MIN_SPACING = 2;

endpackage

// File: rtl/sr_drive_ctrl_sync_debounce.sv
// Input conditioner for one raw request: synchronizer chain, debounce counter
// and a one-cycle event on each rising edge of the debounced level.
module sr_sync_debounce
   import sr_drive_pkg::*;
#(
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DB_CYCLES   = DEF_DB_CYCLES
)(
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic ev
);

   localparam int CW = $clog2(DB_CYCLES + 1);

   logic [SYNC_STAGES-1:0] chain;
   logic                   synced;
   logic                   level;
   logic                   level_d;
   logic [CW-1:0]          cnt;

   assign synced = chain[SYNC_STAGES-1];

   // The level flips on the edge where the mismatch run would reach DB_CYCLES
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         chain   <= '0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
         ev      <= 1'b0;
      end else begin
         chain   <= {chain[SYNC_STAGES-2:0], raw};
         level_d <= level;
         ev      <= level & ~level_d;
         if (synced == level) begin
            cnt <= '0;
         end else if (cnt == CW'(DB_CYCLES - 1)) begin
            level <= ~level;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/sr_drive_ctrl.sv
// Drives an S/R latch with debounced, mutually exclusive fixed-width pulses.
// Optional macro SR_DRIVE_SHADOW_EN adds the q_shadow output and redundant-command dropping.
module sr_drive_ctrl
   import sr_drive_pkg::*;
#(
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
   parameter int DB_CYCLES    = DEF_DB_CYCLES,
   parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
   parameter int CNT_W        = DEF_CNT_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             set_req,
   input  logic             reset_req,
   output logic             s,
   output logic             r,
   output logic             busy,
   output logic [CNT_W-1:0] conflict_cnt
`ifdef SR_DRIVE_SHADOW_EN
   ,
   output logic             q_shadow
`endif
);

   localparam int GUARD_LEN = MIN_SPACING - 1;
   localparam int PMAX      = (PULSE_CYCLES > GUARD_LEN) ? PULSE_CYCLES : GUARD_LEN;
   localparam int PW        = (PMAX > 1) ? $clog2(PMAX) : 1;

   state_t        state;
   logic [PW-1:0] pcnt;
   logic          set_ev;
   logic          rst_ev;
   logic          set_pend;
   logic          rst_pend;
   logic          set_cand;
   logic          rst_cand;
   logic          drop;
   logic          pulse_done;
   logic          guard_done;

   sr_sync_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
   ) u_set_cond (
      .clk (clk),
      .rst (rst),
      .raw (set_req),
      .ev  (set_ev)
   );

   sr_sync_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
   ) u_rst_cond (
      .clk (clk),
      .rst (rst),
      .raw (reset_req),
      .ev  (rst_ev)
   );

   assign set_cand   = set_ev | set_pend;
   assign rst_cand   = rst_ev | rst_pend;
   assign pulse_done = (pcnt == PW'(PULSE_CYCLES - 1));
   assign guard_done = (pcnt == PW'(GUARD_LEN - 1));

`ifdef SR_DRIVE_SHADOW_EN
   // A command that would leave the latch where it already is gets dropped
   assign drop = rst_cand ? ~q_shadow : (set_cand & q_shadow);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_shadow <= 1'b0;
      end else if (pulse_done && state == SET_P) begin
         q_shadow <= 1'b1;
      end else if (pulse_done && state == RST_P) begin
         q_shadow <= 1'b0;
      end
   end
`else
   assign drop = 1'b0;
`endif

   // Reset wins a same-cycle contest; the losing set is discarded, not kept pending
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         pcnt         <= '0;
         s            <= 1'b0;
         r            <= 1'b0;
         busy         <= 1'b0;
         set_pend     <= 1'b0;
         rst_pend     <= 1'b0;
         conflict_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               pcnt <= '0;
               if (rst_cand && set_cand && conflict_cnt != '1) begin
                  conflict_cnt <= conflict_cnt + CNT_W'(1);
               end
               if (rst_cand) begin
                  rst_pend <= 1'b0;
                  set_pend <= 1'b0;
                  if (!drop) begin
                     state <= RST_P;
                     r     <= 1'b1;
                     busy  <= 1'b1;
                  end
               end else if (set_cand) begin
                  set_pend <= 1'b0;
                  if (!drop) begin
                     state <= SET_P;
                     s     <= 1'b1;
                     busy  <= 1'b1;
                  end
               end
            end
            SET_P, RST_P: begin
               if (set_ev) set_pend <= 1'b1;
               if (rst_ev) rst_pend <= 1'b1;
               if (pulse_done) begin
                  state <= GUARD;
                  s     <= 1'b0;
                  r     <= 1'b0;
                  pcnt  <= '0;
               end else begin
                  pcnt <= pcnt + PW'(1);
               end
            end
            GUARD: begin
               if (set_ev) set_pend <= 1'b1;
               if (rst_ev) rst_pend <= 1'b1;
               if (guard_done) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  pcnt  <= '0;
               end else begin
                  pcnt <= pcnt + PW'(1);
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sr_drive_ctrl.md
Name: sr_drive_ctrl

Overview:
- Upstream driver for the cross-coupled sr_latch.
- Takes raw, asynchronous set/reset requests (buttons or pins), then synchronizes and debounces them.
- Converts them into registered, mutually exclusive S/R pulses of fixed width, with a guard gap between pulses.
- The latch therefore never sees s=r=1, so it never enters the invalid state. Conflicts are counted for debug.

Parameters:
- SYNC_STAGES, 2, flops in each input synchronizer chain (min 2).
- DB_CYCLES, 4, consecutive stable synchronized cycles required to change a debounced level (min 1).
- PULSE_CYCLES, 2, cycles s or r is held high per command (min 1).
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous assert, active-high
- set_req  in  1  raw asynchronous set request, active-high
- reset_req  in  1  raw asynchronous reset request, active-high
- s  out  1  registered set drive to latch
- r  out  1  registered reset drive to latch
- busy  out  1  high whenever FSM not IDLE
- conflict_cnt  out  CNT_W  saturating count of simultaneous set/reset decisions

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high. All flops clear on rst immediately, independent of clk.
- Reset values: s=0, r=0, busy=0, conflict_cnt=0, sync chains 0, debounced levels 0, debounce counters 0, pending flags 0, FSM=IDLE.
- Synchronizer: each raw input passes through SYNC_STAGES flops. The last stage is the synchronized level.
- Debounce, per input:
  - A counter counts cycles in which the synchronized level differs from the debounced level.
  - It resets to 0 whenever the two match.
  - When the count reaches DB_CYCLES, the debounced level flips and the counter clears.
  - A rising edge of the debounced level produces a one-cycle event (set_ev / rst_ev). Falling edges produce nothing.
- Pending flags set_pend and rst_pend:
  - Set by the matching event when the FSM is not IDLE.
  - Cleared when consumed.
  - Repeat events while a flag is already set are absorbed, not counted.
- FSM states: IDLE, SET_P, RST_P, GUARD.
  - IDLE: rst_ev or rst_pend -> RST_P. Else set_ev or set_pend -> SET_P. Else stay.
  - SET_P: s=1, r=0 for exactly PULSE_CYCLES cycles, then -> GUARD.
  - RST_P: r=1, s=0 for exactly PULSE_CYCLES cycles, then -> GUARD.
  - GUARD: s=r=0 for exactly 1 cycle, then -> IDLE.
- Conflict rule:
  - Reset wins whenever both requests (event or pending, any mix) are candidates in the same IDLE decision cycle.
  - The losing set request is discarded, not kept pending.
  - conflict_cnt increments by 1 on each such decision and saturates at 2^CNT_W-1.
- s and r are flop outputs. s&r is never 1 in any cycle, including during and after reset.
- Latency: with raw input rising before clk edge 0 and held stable, s (or r) is first high after edge SYNC_STAGES+DB_CYCLES+1. It stays high PULSE_CYCLES cycles.
- Back-to-back commands: minimum spacing between the falling edge of one pulse and the rise of the next is 2 cycles (GUARD, then IDLE decision).
- Reset mid-pulse: s/r drop immediately (asynchronously) and all pending state is lost. After release, requests still held high must re-debounce from 0.
- busy=1 in SET_P, RST_P and GUARD.

Optional Feature:
- Macro: SR_DRIVE_SHADOW_EN.
- With the macro defined:
  - The block keeps a shadow bit q_shadow (reset 0) tracking the expected latch state: set to 1 at the end of SET_P, to 0 at the end of RST_P.
  - An IDLE decision whose winning command matches q_shadow is dropped. The FSM stays in IDLE, no pulse is issued, and the consumed pend flag is cleared.
  - A 1-bit output port q_shadow is added.
- Without the macro: every accepted command is pulsed and no q_shadow port exists.

Decomposition:
- Shared package sr_drive_pkg holds:
  - FSM state enum (IDLE, SET_P, RST_P, GUARD) as 2-bit localparam encodings;
  - default parameter constants;
  - the minimum-spacing constant (2).
- One natural sub-module, sr_sync_debounce: synchronizer plus debouncer plus rising-edge event for one input, instantiated twice.

Test Plan:
- Assert rst, then apply set_req pulses with rst held -> s=r=busy=0 and conflict_cnt=0 throughout. After release, outputs stay 0 until a debounced request arrives.
- Default parameters, set_req=1 held from edge 0 -> s=1 after edges 7 and 8, GUARD at edge 9, busy=0 from edge 10. r stays 0.
- set_req glitch high for 3 cycles (< DB_CYCLES=4) -> no s pulse, busy stays 0.
- set_req and reset_req rise on the same edge -> only r pulses (2 cycles), s never 1, conflict_cnt=1. Repeat 300 times with CNT_W=8 -> conflict_cnt saturates at 255.
- reset_req debounced while SET_P is active -> s completes 2 cycles, then GUARD, IDLE, and RST_P with r=1 for 2 cycles. s&r=0 every cycle.
- Assert rst during SET_P cycle 1 -> s falls without a clk edge and the pending reset is discarded. With SR_DRIVE_SHADOW_EN defined: two successive set commands -> only the first pulses, and q_shadow=1.
